// File: rtl/ex_stage_if.sv
// ---------------------------------------------------------------------------
// ex_stage_if
// Bundle of the execute-stage operand, hazard and result signals.
//   master : producer of operands/hazard info, consumer of registered results
//   slave  : the execute stage itself
// Signals:
//   aluop_i        ALU operation code
//   alusrc1_i/2_i  operands A/B from ID/EX
//   regsrc1_i/2_i  register indices the operands were read from
//   exreg*_i       destination/write/result of the EX/MEM instruction
//   memreg*_i      destination/write/result of the MEM/WB instruction
//   alures_o       registered ALU result
//   alusrc1_o/2_o  registered forwarded operands
// ---------------------------------------------------------------------------
interface ex_stage_if;
    logic [3:0]  aluop_i;
    logic [15:0] alusrc1_i;
    logic [15:0] alusrc2_i;
    logic [3:0]  regsrc1_i;
    logic [3:0]  regsrc2_i;
    logic [3:0]  exregdst_i;
    logic        exregwrite_i;
    logic [15:0] exregdata_i;
    logic [3:0]  memregdst_i;
    logic        memregwrite_i;
    logic [15:0] memregdata_i;
    logic [15:0] alures_o;
    logic [15:0] alusrc1_o;
    logic [15:0] alusrc2_o;

    modport master (
        output aluop_i, alusrc1_i, alusrc2_i, regsrc1_i, regsrc2_i,
        output exregdst_i, exregwrite_i, exregdata_i,
        output memregdst_i, memregwrite_i, memregdata_i,
        input  alures_o, alusrc1_o, alusrc2_o
    );

    modport slave (
        input  aluop_i, alusrc1_i, alusrc2_i, regsrc1_i, regsrc2_i,
        input  exregdst_i, exregwrite_i, exregdata_i,
        input  memregdst_i, memregwrite_i, memregdata_i,
        output alures_o, alusrc1_o, alusrc2_o
    );
endinterface

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage
// Execute stage of the 16-bit five-stage pipeline. Forwards results from the
// EX/MEM and MEM/WB stages onto each operand, runs the ALU on the forwarded
// operands and registers the result together with both forwarded operands
// (one cycle latency, no stall).
// Ports:
//   clk  : pipeline clock, rising edge
//   rst  : asynchronous active-low reset, clears all outputs to 0
//   bus  : ex_stage_if.slave (operands, hazard info, registered results)
// Configuration macro:
//   EX_FWD_EN  defined   -> forwarding enabled (EX/MEM has priority over MEM/WB)
//              undefined -> operands taken straight from ID/EX, hazard inputs
//                           ignored
// ---------------------------------------------------------------------------
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    ex_stage_if.slave   bus
);

    logic [15:0] op_a_s;
    logic [15:0] op_b_s;
    logic [15:0] alu_s;
    logic [15:0] alures_r;
    logic [15:0] alusrc1_r;
    logic [15:0] alusrc2_r;

    // 16-bit wrapping ALU, no flags.
    function automatic logic [15:0] alu_f(input logic [3:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
        logic [15:0] r;
        case (op)
            4'h0:    r = a + b;
            4'h1:    r = a - b;
            4'h2:    r = a & b;
            4'h3:    r = a | b;
            4'h4:    r = a ^ b;
            4'h5:    r = ~a;
            4'h6:    r = a << b[3:0];
            4'h7:    r = a >> b[3:0];
            4'h8:    r = $unsigned($signed(a) >>> b[3:0]);
            4'h9:    r = {15'd0, ($signed(a) < $signed(b))};
            4'hA:    r = {15'd0, (a < b)};
            4'hB:    r = {15'd0, (a != b)};
            4'hC:    r = a;
            4'hD:    r = b;
            4'hE:    r = 16'd0 - a;
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

`ifdef EX_FWD_EN
    // Operand A forwarding: the EX/MEM result is newer, so it wins over MEM/WB.
    always_comb begin
        op_a_s = bus.alusrc1_i;
        if (bus.exregwrite_i && (bus.exregdst_i == bus.regsrc1_i)) begin
            op_a_s = bus.exregdata_i;
        end else if (bus.memregwrite_i && (bus.memregdst_i == bus.regsrc1_i)) begin
            op_a_s = bus.memregdata_i;
        end else begin
            op_a_s = bus.alusrc1_i;
        end
    end

    // Operand B forwarding, same priority as operand A.
    always_comb begin
        op_b_s = bus.alusrc2_i;
        if (bus.exregwrite_i && (bus.exregdst_i == bus.regsrc2_i)) begin
            op_b_s = bus.exregdata_i;
        end else if (bus.memregwrite_i && (bus.memregdst_i == bus.regsrc2_i)) begin
            op_b_s = bus.memregdata_i;
        end else begin
            op_b_s = bus.alusrc2_i;
        end
    end
`else
    // Hazard inputs are intentionally ignored without forwarding.
    logic unused_fwd_s;
    assign unused_fwd_s = ^{bus.regsrc1_i, bus.regsrc2_i,
                            bus.exregdst_i, bus.exregwrite_i, bus.exregdata_i,
                            bus.memregdst_i, bus.memregwrite_i, bus.memregdata_i};

    // Operands pass straight through from ID/EX.
    always_comb begin
        op_a_s = bus.alusrc1_i;
        op_b_s = bus.alusrc2_i;
    end
`endif

    // ALU on the (possibly forwarded) operands.
    always_comb begin
        alu_s = alu_f(bus.aluop_i, op_a_s, op_b_s);
    end

    // Output register: captures result and forwarded operands every edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alures_r  <= 16'h0000;
            alusrc1_r <= 16'h0000;
            alusrc2_r <= 16'h0000;
        end else begin
            alures_r  <= alu_s;
            alusrc1_r <= op_a_s;
            alusrc2_r <= op_b_s;
        end
    end

    assign bus.alures_o  = alures_r;
    assign bus.alusrc1_o = alusrc1_r;
    assign bus.alusrc2_o = alusrc2_r;

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage
// Directed bench for ex_stage. Each step drives one instruction, pushes the
// expected registered outputs into a scoreboard queue, and pops/compares them
// one clock edge later. Expectations for hazard cases depend on EX_FWD_EN.
// ---------------------------------------------------------------------------
module tb_ex_stage;

`ifdef EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   fails;

    typedef struct packed {
        logic [15:0] res;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    exp_t  last_exp;

    ex_stage_if bus ();

    ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic [3:0] exd, input logic exw, input logic [15:0] exdat,
                         input logic [3:0] md, input logic mw, input logic [15:0] mdat);
        bus.aluop_i       = op;
        bus.alusrc1_i     = a;
        bus.alusrc2_i     = b;
        bus.regsrc1_i     = rs1;
        bus.regsrc2_i     = rs2;
        bus.exregdst_i    = exd;
        bus.exregwrite_i  = exw;
        bus.exregdata_i   = exdat;
        bus.memregdst_i   = md;
        bus.memregwrite_i = mw;
        bus.memregdata_i  = mdat;
    endtask

    task automatic pop_check();
        exp_t  e;
        string t;
        if (sb_q.size() == 0) begin
            checks++;
            fails++;
            $error("FAIL sb_empty observed=0 expected=1");
        end else begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            check({t, ".res"}, bus.alures_o, e.res);
            check({t, ".a"},   bus.alusrc1_o, e.a);
            check({t, ".b"},   bus.alusrc2_o, e.b);
            last_exp = e;
        end
    endtask

    // Drive, push expectation, wait one edge, compare.
    task automatic step(input string tag, input logic [3:0] op,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] rs1, input logic [3:0] rs2,
                        input logic [3:0] exd, input logic exw, input logic [15:0] exdat,
                        input logic [3:0] md, input logic mw, input logic [15:0] mdat,
                        input logic [15:0] eres, input logic [15:0] ea, input logic [15:0] eb);
        drive(op, a, b, rs1, rs2, exd, exw, exdat, md, mw, mdat);
        sb_q.push_back('{res: eres, a: ea, b: eb});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    // Hazard-free ALU step: hazard stages write unrelated registers.
    task automatic alu_step(input string tag, input logic [3:0] op,
                            input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] eres);
        step(tag, op, a, b, 4'd1, 4'd2, 4'd3, 1'b1, 16'hDEAD, 4'd4, 1'b1, 16'hBEEF,
             eres, a, b);
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst    = 1'b0;
        drive(4'h0, 16'h1111, 16'h2222, 4'd1, 4'd2, 4'd3, 1'b0, 16'h0, 4'd4, 1'b0, 16'h0);
        #1;
        check("rst_pre.res", bus.alures_o, 16'h0000);
        check("rst_pre.a",   bus.alusrc1_o, 16'h0000);
        check("rst_pre.b",   bus.alusrc2_o, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check("rst_edge.res", bus.alures_o, 16'h0000);
        check("rst_edge.a",   bus.alusrc1_o, 16'h0000);
        check("rst_edge.b",   bus.alusrc2_o, 16'h0000);

        rst = 1'b1;
        step("rst_release", 4'h0, 16'h1111, 16'h2222, 4'd1, 4'd2, 4'd3, 1'b0, 16'h0,
             4'd4, 1'b0, 16'h0, 16'h3333, 16'h1111, 16'h2222);

        // Split forwarding: A from EX/MEM, B from MEM/WB.
        step("split_fwd", 4'h0, 16'hFFF1, 16'h001F, 4'd5, 4'd3, 4'd5, 1'b1, 16'hFFF0,
             4'd3, 1'b1, 16'h000F,
             FWD ? 16'hFFFF : 16'h0010, FWD ? 16'hFFF0 : 16'hFFF1, FWD ? 16'h000F : 16'h001F);

        // EX/MEM wins when both stages match.
        step("priority", 4'h0, 16'h000F, 16'h00F0, 4'd5, 4'd7, 4'd7, 1'b1, 16'h0F00,
             4'd7, 1'b1, 16'hF000,
             FWD ? 16'h0F0F : 16'h00FF, 16'h000F, FWD ? 16'h0F00 : 16'h00F0);

        step("ex_wr_off", 4'h0, 16'h000F, 16'h00F0, 4'd5, 4'd7, 4'd7, 1'b0, 16'h0F00,
             4'd7, 1'b1, 16'hF000,
             FWD ? 16'hF00F : 16'h00FF, 16'h000F, FWD ? 16'hF000 : 16'h00F0);

        step("both_wr_off", 4'h0, 16'h000F, 16'h00F0, 4'd5, 4'd7, 4'd7, 1'b0, 16'h0F00,
             4'd7, 1'b0, 16'hF000, 16'h00FF, 16'h000F, 16'h00F0);

        // Register 0 is forwarded like any other index.
        step("idx0_fwd", 4'hC, 16'h1234, 16'h5678, 4'd0, 4'd9, 4'd0, 1'b1, 16'hABCD,
             4'd9, 1'b1, 16'h0F0F,
             FWD ? 16'hABCD : 16'h1234, FWD ? 16'hABCD : 16'h1234, FWD ? 16'h0F0F : 16'h5678);

        // ALU sweep, A=8001 B=0003.
        alu_step("add",   4'h0, 16'h8001, 16'h0003, 16'h8004);
        alu_step("sub",   4'h1, 16'h8001, 16'h0003, 16'h7FFE);
        alu_step("and",   4'h2, 16'h8001, 16'h0003, 16'h0001);
        alu_step("or",    4'h3, 16'h8001, 16'h0003, 16'h8003);
        alu_step("xor",   4'h4, 16'h8001, 16'h0003, 16'h8002);
        alu_step("not",   4'h5, 16'h8001, 16'h0003, 16'h7FFE);
        alu_step("sll",   4'h6, 16'h8001, 16'h0003, 16'h0008);
        alu_step("srl",   4'h7, 16'h8001, 16'h0003, 16'h1000);
        alu_step("sra",   4'h8, 16'h8001, 16'h0003, 16'hF000);
        alu_step("slt",   4'h9, 16'h8001, 16'h0003, 16'h0001);
        alu_step("sltu",  4'hA, 16'h8001, 16'h0003, 16'h0000);
        alu_step("cmp",   4'hB, 16'h8001, 16'h0003, 16'h0001);
        alu_step("passa", 4'hC, 16'h8001, 16'h0003, 16'h8001);
        alu_step("passb", 4'hD, 16'h8001, 16'h0003, 16'h0003);
        alu_step("neg",   4'hE, 16'h8001, 16'h0003, 16'h7FFF);
        alu_step("opf",   4'hF, 16'h8001, 16'h0003, 16'h0000);

        // Additional boundaries.
        alu_step("cmp_eq",   4'hB, 16'h5A5A, 16'h5A5A, 16'h0000);
        alu_step("sltu_lt",  4'hA, 16'h0003, 16'h8001, 16'h0001);
        alu_step("slt_ge",   4'h9, 16'h0003, 16'h8001, 16'h0000);
        alu_step("sra_pos",  4'h8, 16'h7000, 16'h0004, 16'h0700);
        alu_step("sll_15",   4'h6, 16'h0001, 16'h001F, 16'h8000);
        alu_step("add_wrap", 4'h0, 16'hFFFF, 16'h0001, 16'h0000);
        alu_step("sub_wrap", 4'h1, 16'h0000, 16'h0001, 16'hFFFF);

        // Inputs changing between edges must not reach the outputs.
        drive(4'h3, 16'h0F0F, 16'hF0F0, 4'd1, 4'd2, 4'd3, 1'b0, 16'h0, 4'd4, 1'b0, 16'h0);
        #3;
        check("hold.res", bus.alures_o, last_exp.res);
        check("hold.a",   bus.alusrc1_o, last_exp.a);
        check("hold.b",   bus.alusrc2_o, last_exp.b);

        // Asynchronous reset mid-cycle clears outputs immediately.
        rst = 1'b0;
        #1;
        check("async_rst.res", bus.alures_o, 16'h0000);
        check("async_rst.a",   bus.alusrc1_o, 16'h0000);
        check("async_rst.b",   bus.alusrc2_o, 16'h0000);
        rst = 1'b1;
        step("post_rst", 4'h3, 16'h0F0F, 16'hF0F0, 4'd1, 4'd2, 4'd3, 1'b0, 16'h0,
             4'd4, 1'b0, 16'h0, 16'hFFFF, 16'h0F0F, 16'hF0F0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
